raw10_depacker: RTL
===================

RAW10_DEPACKER -- requirements
Module: raw10_depacker

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset; no other clock domains.
REQ-002 clk_i  input  1  MIPI byte clock; all state changes on its rising edge.
REQ-003 reset_i  input  1  asynchronous, active-low reset.
REQ-004 line_valid_i  input  1  high for the duration of one image line's payload.
REQ-005 data_valid_i  input  1  data_i carries 4 valid payload bytes this cycle.
REQ-006 data_i  input  32  4 payload bytes; [7:0] is the first byte received, [31:24] the last.
REQ-007 output_valid_o  output  1  output_o holds 4 valid pixels this cycle.
REQ-008 output_o  output  40  4x10-bit pixels; first pixel in [39:30], last pixel in [9:0].
REQ-009 line_valid_o  output  1  line_valid_i delayed to align with output_o.

Function
REQ-010 SHALL decode RAW10 5-byte groups: B0..B3 are pixels P0..P3 bits [9:2]; B4 = {P3[1:0], P2[1:0], P1[1:0], P0[1:0]}.
REQ-011 SHALL hold an 8-byte carry buffer and a byte count cnt (0..4 between cycles).
REQ-012 On an accepted cycle (line_valid_i && data_valid_i), SHALL append the 4 bytes after the cnt held bytes, giving cnt+4 bytes.
REQ-013 If cnt+4 >= 5, SHALL emit the oldest 5 bytes as one pixel group, retain the rest, and set cnt to cnt-1.
REQ-014 If cnt+4 < 5, SHALL set cnt to 4 with no output.
REQ-015 From a line start, cnt SHALL follow 0->4->3->2->1->0; output is valid on 4 of every 5 accepted cycles, starting at the 2nd.
REQ-016 Latency SHALL be exactly 1 clock from the accepted input cycle that completes a group to output_valid_o=1.
REQ-017 output_valid_o SHALL be a single-cycle pulse per group; output_o holds its last value when output_valid_o=0.
REQ-018 data_valid_i=0 while line_valid_i=1 SHALL hold cnt and the buffer unchanged (stall); no output that cycle.
REQ-019 line_valid_i=0 SHALL clear cnt to 0 and discard partial bytes; data_valid_i is ignored (simultaneous case included).
REQ-020 Partial bytes at line end (line length not a multiple of 5 bytes) SHALL be dropped silently; no output flush.
REQ-021 line_valid_o SHALL equal line_valid_i registered once.
REQ-022 No back-pressure: the block SHALL accept every valid cycle; no ready signal exists.

Reset
REQ-023 While reset_i=0: output_valid_o=0, output_o=0, line_valid_o=0, cnt=0, buffer=0.
REQ-024 Reset asserted mid-group SHALL discard all held bytes; the first accepted cycle after release is byte 0 of a new group.
REQ-025 Reset deassertion SHALL take effect on the next clk_i rising edge; no output during that edge.

Structure
REQ-026 Shared package SHALL hold RAW10_IN_WIDTH=32, RAW10_OUT_WIDTH=40, RAW10_GROUP_BYTES=5, PIXEL_WIDTH=10.
REQ-027 SHALL instantiate one combinational sub-module, raw10_group_unpack (40-bit 5-byte group in, 40-bit 4-pixel out), per REQ-010.
REQ-028 output_o SHALL connect directly to the 40-bit pixel input of the downstream debayer stage with no reformatting.

Verification
REQ-029 Single group: line_valid_i=1; words 0x78563412, 0x000000E4 -> one pulse, 1 clk after word 2: output_o = {0x048, 0x0D1, 0x15A, 0x1E3}.
REQ-030 Steady stream: 5 consecutive accepted words (20 bytes) -> exactly 4 output pulses, on accepted cycles 2-5 (+1 clk); cnt returns to 0.
REQ-031 Stall: the same 5 words with data_valid_i=0 gaps between them -> the same 4 pixel groups in the same order; no pulses during gaps.
REQ-032 Line end mid-group: 3 words, then line_valid_i=0, then new line of 2 words 0x78563412, 0x000000E4 -> REQ-029 values; the 2 leftover bytes of the first line never appear.
REQ-033 Reset mid-line: assert reset_i=0 after 2 words -> all outputs 0 immediately (asynchronous); after release, the REQ-029 stimulus gives the REQ-029 result.
REQ-034 All-ones: 5 bytes of 0xFF -> output_o = 40'hFF_FFFF_FFFF (each pixel 0x3FF).

Source files
------------

// File: rtl/raw10_depacker_pkg.sv
// Shared widths and types for the RAW10 depacker and its group unpacker.
package raw10_depacker_pkg;

    localparam int RAW10_IN_WIDTH    = 32;
    localparam int RAW10_OUT_WIDTH   = 40;
    localparam int RAW10_GROUP_BYTES = 5;
    localparam int PIXEL_WIDTH       = 10;
    localparam int RAW10_BUF_WIDTH   = 64;
    localparam int RAW10_GROUP_BITS  = RAW10_GROUP_BYTES * 8;

    typedef logic [2:0] cnt_t;

    localparam cnt_t CNT_EMPTY = 3'd0;
    localparam cnt_t CNT_FULL  = 3'd4;

endpackage

// File: rtl/raw10_depacker_if.sv
// Byte-stream input and pixel-group output bundle of the RAW10 depacker.
interface raw10_depacker_if;
    import raw10_depacker_pkg::*;

    logic                       line_valid_i;
    logic                       data_valid_i;
    logic [RAW10_IN_WIDTH-1:0]  data_i;
    logic                       output_valid_o;
    logic [RAW10_OUT_WIDTH-1:0] output_o;
    logic                       line_valid_o;

    modport master (
        output line_valid_i,
        output data_valid_i,
        output data_i,
        input  output_valid_o,
        input  output_o,
        input  line_valid_o
    );

    modport slave (
        input  line_valid_i,
        input  data_valid_i,
        input  data_i,
        output output_valid_o,
        output output_o,
        output line_valid_o
    );

endinterface

// File: rtl/raw10_group_unpack.sv
// Combinational RAW10 unpack: 5 bytes (B0 in [7:0]) to 4 pixels (P0 in [39:30]).
module raw10_group_unpack
    import raw10_depacker_pkg::*;
(
    input  logic [RAW10_GROUP_BITS-1:0] i_group,
    output logic [RAW10_OUT_WIDTH-1:0]  o_pixels
);

    // B4 carries the two LSBs of every pixel, P0 in its lowest bit pair.
    for (genvar k = 0; k < 4; k++) begin : g_pix
        assign o_pixels[RAW10_OUT_WIDTH-1-PIXEL_WIDTH*k -: PIXEL_WIDTH] =
            {i_group[8*k +: 8], i_group[32+2*k +: 2]};
    end

endmodule

// File: rtl/raw10_depacker.sv
// RAW10 depacker: 4-byte words in, one 4-pixel group out per 5 bytes consumed.
module raw10_depacker
    import raw10_depacker_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    raw10_depacker_if.slave  bus
);

    logic [RAW10_BUF_WIDTH-1:0]  r_buf;
    cnt_t                        r_cnt;
    logic                        r_out_valid;
    logic [RAW10_OUT_WIDTH-1:0]  r_out;
    logic                        r_line_valid;

    logic [RAW10_BUF_WIDTH-1:0]  w_cat;
    logic                        w_emit;
    logic [RAW10_GROUP_BITS-1:0] w_group;
    logic [RAW10_OUT_WIDTH-1:0]  w_pixels;

    // Append the incoming word behind the held bytes; a group completes whenever cnt was non-zero.
    always_comb begin
        w_cat   = r_buf | ({32'd0, bus.data_i} << {r_cnt, 3'b000});
        w_group = w_cat[RAW10_GROUP_BITS-1:0];
        if (r_cnt != CNT_EMPTY) begin
            w_emit = 1'b1;
        end else begin
            w_emit = 1'b0;
        end
    end

    raw10_group_unpack u_unpack (
        .i_group  (w_group),
        .o_pixels (w_pixels)
    );

    // Carry buffer, byte count and registered outputs.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_buf        <= 64'd0;
            r_cnt        <= CNT_EMPTY;
            r_out_valid  <= 1'b0;
            r_out        <= 40'd0;
            r_line_valid <= 1'b0;
        end else begin
            r_line_valid <= bus.line_valid_i;
            if (!bus.line_valid_i) begin
                r_buf       <= 64'd0;
                r_cnt       <= CNT_EMPTY;
                r_out_valid <= 1'b0;
            end else if (bus.data_valid_i) begin
                if (w_emit) begin
                    r_buf       <= w_cat >> RAW10_GROUP_BITS;
                    r_cnt       <= r_cnt - 3'd1;
                    r_out_valid <= 1'b1;
                    r_out       <= w_pixels;
                end else begin
                    r_buf       <= w_cat;
                    r_cnt       <= CNT_FULL;
                    r_out_valid <= 1'b0;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.output_valid_o = r_out_valid;
    assign bus.output_o       = r_out;
    assign bus.line_valid_o   = r_line_valid;

endmodule
